// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared constants for the RTC bus controller.
//   - PicoBlaze port map (write and read-back port IDs)
//   - bus FSM state encoding
//   - command register bit positions
package rtc_bus_pkg;

    localparam logic [7:0] PORT_ADDR  = 8'h01;
    localparam logic [7:0] PORT_WDATA = 8'h02;
    localparam logic [7:0] PORT_CMD   = 8'h03;
    localparam logic [7:0] PORT_STAT  = 8'h04;
    localparam logic [7:0] PORT_RDATA = 8'h05;

    localparam int CMD_WR_BIT = 0;
    localparam int CMD_RD_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_A_ACT = 3'd1,
        ST_A_GAP = 3'd2,
        ST_D_ACT = 3'd3,
        ST_D_GAP = 3'd4
    } state_t;

endpackage

// File: rtl/rtc_bus_ctrl_timer.sv
// rtc_phase_timer: loadable down-counter timing one bus phase.
//   clk, rst : clock, async active-high reset
//   load     : restart the phase (counter <= T_PHASE-1)
//   done     : high on the last cycle of the phase (count == 0)
module rtc_phase_timer #(
    parameter int T_PHASE = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int             W        = $clog2(T_PHASE);
    localparam logic [W-1:0]   LOAD_VAL = W'(T_PHASE - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                cnt_q <= '0;
        else if (load)          cnt_q <= LOAD_VAL;
        else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: PicoBlaze port-mapped controller for a multiplexed A/D RTC bus.
//   clk, rst                 : clock, async active-high reset
//   port_id/out_port/
//   write_strobe             : PicoBlaze OUTPUT interface (ADDR, WDATA, CMD)
//   in_port                  : registered read-back (STAT=busy, RDATA)
//   irq / irq_ack            : transaction-done interrupt
//   cs_n, rd_n, wr_n, ad_sel : RTC strobes and A/D phase select
//   ad_o, ad_oe, ad_i        : bus drive value, drive enable, sampled value
// Optional feature macro: RTC_BUS_IRQ_EN enables irq; otherwise irq is 0.
module rtc_bus_ctrl
    import rtc_bus_pkg::*;
#(
    parameter int T_PHASE = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    output logic [7:0] in_port,
    output logic       irq,
    input  logic       irq_ack,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_sel,
    output logic [7:0] ad_o,
    output logic       ad_oe,
    input  logic [7:0] ad_i
);

    state_t     state_q, state_d;
    logic [7:0] addr_q, wdata_q, rdata_q;
    logic [7:0] tx_addr_q, tx_wdata_q;   // snapshot taken at command time
    logic       tx_wr_q;
    logic [7:0] in_port_q, in_port_d;
    logic       busy, start, ph_load, ph_done;

    assign busy  = (state_q != ST_IDLE);
    assign start = write_strobe && (port_id == PORT_CMD) && !busy &&
                   (out_port[CMD_WR_BIT] || out_port[CMD_RD_BIT]);
    // Reload on every phase boundary so each state lasts exactly T_PHASE.
    assign ph_load = start || (busy && ph_done);

    rtc_phase_timer #(.T_PHASE(T_PHASE)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (ph_load),
        .done (ph_done)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)   state_d = ST_A_ACT;
            ST_A_ACT: if (ph_done) state_d = ST_A_GAP;
            ST_A_GAP: if (ph_done) state_d = ST_D_ACT;
            ST_D_ACT: if (ph_done) state_d = ST_D_GAP;
            ST_D_GAP: if (ph_done) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Bus outputs decoded from state, so reset forces them inactive at once
    always_comb begin
        cs_n   = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        ad_sel = 1'b1;
        ad_oe  = 1'b0;
        ad_o   = 8'h00;
        case (state_q)
            ST_A_ACT: begin
                cs_n = 1'b0; wr_n = 1'b0; ad_sel = 1'b0;
                ad_oe = 1'b1; ad_o = tx_addr_q;
            end
            ST_A_GAP: begin
                ad_sel = 1'b0; ad_oe = 1'b1; ad_o = tx_addr_q;
            end
            ST_D_ACT: begin
                cs_n = 1'b0;
                if (tx_wr_q) begin
                    wr_n = 1'b0; ad_oe = 1'b1; ad_o = tx_wdata_q;
                end else begin
                    rd_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Register file and transaction snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            tx_addr_q  <= 8'h00;
            tx_wdata_q <= 8'h00;
            tx_wr_q    <= 1'b0;
        end else begin
            if (write_strobe && port_id == PORT_ADDR)  addr_q  <= out_port;
            if (write_strobe && port_id == PORT_WDATA) wdata_q <= out_port;
            if (start) begin
                tx_addr_q  <= addr_q;
                tx_wdata_q <= wdata_q;
                tx_wr_q    <= out_port[CMD_WR_BIT];   // write wins over read
            end
            if (state_q == ST_D_ACT && ph_done && !tx_wr_q) rdata_q <= ad_i;
        end
    end

    // Read-back mux, one cycle latency
    always_comb begin
        in_port_d = 8'h00;
        case (port_id)
            PORT_STAT:  in_port_d = {7'b0, busy};
            PORT_RDATA: in_port_d = rdata_q;
            default:    in_port_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_port_q <= 8'h00;
        else     in_port_q <= in_port_d;
    end
    assign in_port = in_port_q;

`ifdef RTC_BUS_IRQ_EN
    logic irq_q;
    // Set on leaving D_GAP; a simultaneous ack does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  irq_q <= 1'b0;
        else if (state_q == ST_D_GAP && ph_done)  irq_q <= 1'b1;
        else if (irq_ack)                         irq_q <= 1'b0;
    end
    assign irq = irq_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
    assign irq = 1'b0;
`endif

endmodule
